// File: rtl/mu0_core_p.sv
// ---------------------------------------------------------------------------
// mu0_core_p : parametrised MU0 processor core with a memory ready handshake.
//
// This is a three-state control unit (FETCH / EXEC / HALT) with stallable
// memory accesses. An access completes at the rising edge where Ack is high.
//
// Parameters
//   DATA_W : data, accumulator and instruction width (>= 8)
//   ADDR_W : address / PC width. Must equal DATA_W-4, because the opcode is
//            always the top nibble of IR.
//
// Ports
//   Clk     : clock; all state changes on the rising edge
//   reset_n : asynchronous active-low reset
//   DIn     : read data, captured when Rd and Ack are both high
//   Ack     : memory ready; completes the current Rd/Wr access
//   Go      : restart request, honoured only while halted
//   Addr    : memory address (PC unless an operand access is in progress)
//   Rd / Wr : read / write request, never both high
//   DOut    : write data, always equal to Acc
//   Halted  : high in the HALT state
//   PC, IR, Acc : architectural registers
// ---------------------------------------------------------------------------
module mu0_core_p #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = DATA_W - 4
) (
    input  logic              Clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] DIn,
    input  logic              Ack,
    input  logic              Go,
    output logic [ADDR_W-1:0] Addr,
    output logic              Rd,
    output logic              Wr,
    output logic [DATA_W-1:0] DOut,
    output logic              Halted,
    output logic [ADDR_W-1:0] PC,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] Acc
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JGE = 4'h5;
    localparam logic [3:0] OP_JNE = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;
    localparam logic [3:0] OP_AND = 4'h8;
    localparam logic [3:0] OP_OR  = 4'h9;
    localparam logic [3:0] OP_LDI = 4'hA;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state_r;
    logic [ADDR_W-1:0]   pc_r;
    logic [DATA_W-1:0]   ir_r;
    logic [DATA_W-1:0]   acc_r;

    logic [3:0]          opcode_s;
    logic [ADDR_W-1:0]   operand_s;
    logic                mem_op_s;
    logic [ADDR_W-1:0]   addr_s;
    logic                rd_s;
    logic                wr_s;
    logic                halted_s;

    // Opcodes that touch data memory and therefore wait for Ack in EXEC.
    function automatic logic is_mem_op(input logic [3:0] op);
        case (op)
            OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_OR: is_mem_op = 1'b1;
            default:                                       is_mem_op = 1'b0;
        endcase
    endfunction

    assign opcode_s  = ir_r[DATA_W-1 -: 4];
    assign operand_s = ir_r[ADDR_W-1:0];
    assign mem_op_s  = is_mem_op(opcode_s);

    // Bus request decode: depends only on state, IR and PC (no DIn path).
    always_comb begin
        rd_s     = 1'b0;
        wr_s     = 1'b0;
        addr_s   = pc_r;
        halted_s = 1'b0;
        case (state_r)
            ST_FETCH: begin
                rd_s = 1'b1;
            end
            ST_EXEC: begin
                if (mem_op_s) begin
                    addr_s = operand_s;
                    if (opcode_s == OP_STA) begin
                        wr_s = 1'b1;
                    end else begin
                        rd_s = 1'b1;
                    end
                end else begin
                    addr_s = pc_r;
                end
            end
            ST_HALT: begin
                halted_s = 1'b1;
            end
            default: begin
                addr_s = pc_r;
            end
        endcase
    end

    // Control FSM and architectural register updates.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_FETCH;
            pc_r    <= {ADDR_W{1'b0}};
            ir_r    <= {DATA_W{1'b0}};
            acc_r   <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (Ack) begin
                        ir_r    <= DIn;
                        pc_r    <= pc_r + PC_ONE;
                        state_r <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Memory operations stay in EXEC until Ack; the rest finish now.
                    if (!mem_op_s || Ack) begin
                        state_r <= ST_FETCH;
                    end
                    case (opcode_s)
                        OP_LDA: if (Ack) acc_r <= DIn;
                        OP_ADD: if (Ack) acc_r <= acc_r + DIn;
                        OP_SUB: if (Ack) acc_r <= acc_r - DIn;
                        OP_AND: if (Ack) acc_r <= acc_r & DIn;
                        OP_OR:  if (Ack) acc_r <= acc_r | DIn;
                        OP_JMP: pc_r <= operand_s;
                        OP_JGE: if (!acc_r[DATA_W-1]) pc_r <= operand_s;
                        OP_JNE: if (acc_r != {DATA_W{1'b0}}) pc_r <= operand_s;
                        OP_LDI: acc_r <= {{(DATA_W-ADDR_W){1'b0}}, operand_s};
                        OP_STP: state_r <= ST_HALT;
                        default: begin
                            // STA only waits for Ack; B..F are NOPs.
                        end
                    endcase
                end
                ST_HALT: begin
                    if (Go) begin
                        state_r <= ST_FETCH;
                    end
                end
                default: begin
                    state_r <= ST_FETCH;
                end
            endcase
        end
    end

    assign Addr   = addr_s;
    assign Rd     = rd_s;
    assign Wr     = wr_s;
    assign Halted = halted_s;
    assign DOut   = acc_r;
    assign PC     = pc_r;
    assign IR     = ir_r;
    assign Acc    = acc_r;

endmodule

// File: tb/tb_mu0_core_p.sv
// ---------------------------------------------------------------------------
// tb_mu0_core_p : self-checking bench for mu0_core_p.
// A 16-bit core runs directed programs and a random program. Each is checked
// against an instruction-level interpreter of the MU0 ISA. A 24-bit core
// checks LDI zero-extension and the 0xF NOP.
// ---------------------------------------------------------------------------
module tb_mu0_core_p;

    logic        Clk = 1'b0;
    logic        reset_n;
    logic        Ack;
    logic        Go;
    logic [15:0] DIn;
    logic [11:0] Addr;
    logic        Rd;
    logic        Wr;
    logic [15:0] DOut;
    logic        Halted;
    logic [11:0] PC;
    logic [15:0] IR;
    logic [15:0] Acc;

    // 24-bit instance
    logic        rst24_n;
    logic        ack24;
    logic        go24;
    logic [23:0] din24;
    logic [19:0] addr24;
    logic        rd24;
    logic        wr24;
    logic [23:0] dout24;
    logic        halted24;
    logic [19:0] pc24;
    logic [23:0] ir24;
    logic [23:0] acc24;

    // bench-side memory (what the DUT sees) and the model's memory
    logic [15:0] mem [0:4095];
    logic [15:0] mm  [0:4095];
    int          wr_cnt = 0;

    // reference ISA state
    logic [11:0] m_pc;
    logic [15:0] m_acc;
    logic [15:0] m_ir;
    logic        m_halt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [27:0] exp_tab [0:14];

    always #5 Clk = ~Clk;

    assign DIn   = mem[Addr];
    assign din24 = (addr24 == 20'h00000) ? 24'hA12345 :
                   (addr24 == 20'h00001) ? 24'hF00000 : 24'h000000;

    mu0_core_p #(.DATA_W(16)) u_dut (
        .Clk(Clk), .reset_n(reset_n), .DIn(DIn), .Ack(Ack), .Go(Go),
        .Addr(Addr), .Rd(Rd), .Wr(Wr), .DOut(DOut), .Halted(Halted),
        .PC(PC), .IR(IR), .Acc(Acc)
    );

    mu0_core_p #(.DATA_W(24)) u_dut24 (
        .Clk(Clk), .reset_n(rst24_n), .DIn(din24), .Ack(ack24), .Go(go24),
        .Addr(addr24), .Rd(rd24), .Wr(wr24), .DOut(dout24), .Halted(halted24),
        .PC(pc24), .IR(ir24), .Acc(acc24)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // One clock: record a write the DUT completes at this edge, then move to the next negedge.
    task automatic cycle();
        if (Wr === 1'b1 && Ack === 1'b1) begin
            mem[Addr] = DOut;
            wr_cnt++;
        end
        @(negedge Clk);
    endtask

    // Interpreter: execute one whole MU0 instruction.
    task automatic model_exec();
        logic [3:0]  op;
        logic [11:0] a;
        m_ir = mm[m_pc];
        m_pc = m_pc + 12'd1;
        op   = m_ir[15:12];
        a    = m_ir[11:0];
        case (op)
            4'h0: m_acc = mm[a];
            4'h1: mm[a] = m_acc;
            4'h2: m_acc = m_acc + mm[a];
            4'h3: m_acc = m_acc - mm[a];
            4'h8: m_acc = m_acc & mm[a];
            4'h9: m_acc = m_acc | mm[a];
            4'h4: m_pc = a;
            4'h5: if ($signed(m_acc) >= 0) m_pc = a;
            4'h6: if (m_acc != 16'h0000) m_pc = a;
            4'hA: m_acc = {4'h0, a};
            4'h7: m_halt = 1'b1;
            default: ;
        endcase
    endtask

    task automatic model_reset();
        m_pc = 12'h000; m_acc = 16'h0000; m_ir = 16'h0000; m_halt = 1'b0;
    endtask

    task automatic chk_reset();
        chk("rst_pc", PC, 0);     chk("rst_ir", IR, 0);   chk("rst_acc", Acc, 0);
        chk("rst_rd", Rd, 1);     chk("rst_wr", Wr, 0);   chk("rst_addr", Addr, 0);
        chk("rst_halted", Halted, 0); chk("rst_dout", DOut, 0);
    endtask

    // Run one instruction on the DUT with fs fetch stalls and es exec stalls.
    task automatic dut_instr(input int fs, input int es);
        logic [15:0] e_ir;
        logic [11:0] e_pc1;
        logic [11:0] e_a;
        logic [3:0]  e_op;
        logic        memop;
        int          w0;
        w0    = wr_cnt;
        e_ir  = mm[m_pc];
        e_pc1 = m_pc + 12'd1;
        e_op  = e_ir[15:12];
        e_a   = e_ir[11:0];
        memop = (e_op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h8, 4'h9});
        for (int i = 0; i <= fs; i++) begin
            Ack = (i == fs);
            Go  = 1'($urandom_range(0, 1));
            chk("fetch_rd", Rd, 1);   chk("fetch_wr", Wr, 0);
            chk("fetch_addr", Addr, m_pc); chk("fetch_ir_hold", IR, m_ir);
            chk("fetch_halted", Halted, 0);
            cycle();
        end
        chk("fetch_ir", IR, e_ir);
        chk("fetch_pc", PC, e_pc1);
        if (memop) begin
            for (int i = 0; i <= es; i++) begin
                Ack = (i == es);
                Go  = 1'($urandom_range(0, 1));
                chk("exec_rd", Rd, (e_op != 4'h1));
                chk("exec_wr", Wr, (e_op == 4'h1));
                chk("exec_addr", Addr, e_a);
                chk("exec_dout", DOut, m_acc);
                cycle();
            end
        end else begin
            Ack = 1'($urandom_range(0, 1));
            Go  = 1'($urandom_range(0, 1));
            chk("exec_rd0", Rd, 0); chk("exec_wr0", Wr, 0); chk("exec_addr_pc", Addr, e_pc1);
            cycle();
        end
        Go = 1'b0;
        model_exec();
        chk("pc", PC, m_pc);   chk("acc", Acc, m_acc);
        chk("ir", IR, m_ir);   chk("halted", Halted, m_halt);
        if (e_op == 4'h1) begin
            chk("sta_count", wr_cnt - w0, 1);
            chk("sta_data", mem[e_a], mm[e_a]);
        end else begin
            chk("no_write", wr_cnt - w0, 0);
        end
    endtask

    // Hold HALT for n cycles, then pulse Go.
    task automatic restart(input int n);
        for (int i = 0; i < n; i++) begin
            Go  = 1'b0;
            Ack = 1'($urandom_range(0, 1));
            chk("halt_hold", Halted, 1); chk("halt_rd", Rd, 0);
            chk("halt_wr", Wr, 0);       chk("halt_addr", Addr, m_pc);
            cycle();
        end
        Go = 1'b1;
        chk("halt_before_go", Halted, 1);
        cycle();
        Go = 1'b0;
        chk("go_rd", Rd, 1); chk("go_addr", Addr, m_pc); chk("go_halted", Halted, 0);
        m_halt = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 16'h0000;
            mm[i]  = 16'h0000;
        end
    endtask

    task automatic put(input logic [11:0] a, input logic [15:0] d);
        mem[a] = d;
        mm[a]  = d;
    endtask

    task automatic reset_pulse();
        @(negedge Clk);
        reset_n = 1'b0;
        Ack = 1'b0;
        Go = 1'b0;
        #2;
        chk_reset();
        @(negedge Clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int w0;
        reset_n = 1'b1; rst24_n = 1'b1; ack24 = 1'b1; go24 = 1'b0;
        Ack = 1'b0; Go = 1'b0;
        clear_mem();
        model_reset();
        #1;
        reset_n = 1'b0; rst24_n = 1'b0;
        #1;
        chk_reset();

        // zero-wait program: 5 + 3 stored to 0x012, then STP
        put(12'h000, 16'h0010); put(12'h001, 16'h2011);
        put(12'h002, 16'h1012); put(12'h003, 16'h7000);
        put(12'h010, 16'h0005); put(12'h011, 16'h0003);
        @(negedge Clk);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) dut_instr(0, 0);
        chk("prog_pc", PC, 12'h004);
        chk("prog_halted", Halted, 1);
        chk("prog_mem12", mem[12'h012], 16'h0008);
        restart(5);
        chk("restart_addr", Addr, 12'h004);

        // reset in the middle of a stalled STA
        put(12'h004, 16'h1012);
        w0 = wr_cnt;
        Ack = 1'b1; cycle();
        Ack = 1'b0; cycle();
        chk("stall_sta_wr", Wr, 1);
        chk("stall_sta_addr", Addr, 12'h012);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset();
        chk("reset_no_write", wr_cnt - w0, 0);
        @(negedge Clk);
        reset_n = 1'b1;
        model_reset();
        chk("first_fetch_addr", Addr, 12'h000);

        // wait states on a fetch and on a STA
        dut_instr(3, 0);
        dut_instr(0, 0);
        dut_instr(0, 3);
        dut_instr(0, 0);
        restart(2);

        // branches, arithmetic and PC wrap
        clear_mem();
        put(12'h000, 16'h0010); put(12'h001, 16'h5100);
        put(12'h002, 16'hA000); put(12'h003, 16'h5100);
        put(12'h100, 16'h6200); put(12'h101, 16'hA001); put(12'h102, 16'h6200);
        put(12'h200, 16'h0011); put(12'h201, 16'h2012);
        put(12'h202, 16'h0013); put(12'h203, 16'h8014);
        put(12'h204, 16'h9015); put(12'h205, 16'h3016);
        put(12'h206, 16'h4FFF); put(12'hFFF, 16'hB000);
        put(12'h010, 16'h8000); put(12'h011, 16'hFFFF); put(12'h012, 16'h0002);
        put(12'h013, 16'h0F0F); put(12'h014, 16'h00FF); put(12'h015, 16'h0F00);
        put(12'h016, 16'h0010);
        exp_tab = '{ {12'h001, 16'h8000}, {12'h002, 16'h8000}, {12'h003, 16'h0000},
                     {12'h100, 16'h0000}, {12'h101, 16'h0000}, {12'h102, 16'h0001},
                     {12'h200, 16'h0001}, {12'h201, 16'hFFFF}, {12'h202, 16'h0001},
                     {12'h203, 16'h0F0F}, {12'h204, 16'h000F}, {12'h205, 16'h0F0F},
                     {12'h206, 16'h0EFF}, {12'hFFF, 16'h0EFF}, {12'h000, 16'h0EFF} };
        reset_pulse();
        for (int k = 0; k < 15; k++) begin
            dut_instr(k % 2, (k / 2) % 3);
            chk("tab_pc", PC, exp_tab[k][27:16]);
            chk("tab_acc", Acc, exp_tab[k][15:0]);
        end
        chk("wrap_fetch_addr", Addr, 12'h000);
        chk("wrap_fetch_rd", Rd, 1);

        // random program against the interpreter
        for (int i = 0; i < 4096; i++) put(i[11:0], 16'($urandom));
        reset_pulse();
        for (int k = 0; k < 400; k++) begin
            if (m_halt) restart($urandom_range(0, 2));
            dut_instr($urandom_range(0, 2), $urandom_range(0, 2));
        end

        // 24-bit core: LDI zero-extends, opcode F is a NOP
        @(negedge Clk);
        rst24_n = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        chk("w24_ldi_acc", acc24, 24'h012345);
        chk("w24_ldi_pc", pc24, 20'h00001);
        @(negedge Clk);
        @(negedge Clk);
        chk("w24_nop_pc", pc24, 20'h00002);
        chk("w24_nop_acc", acc24, 24'h012345);
        chk("w24_nop_ir", ir24, 24'hF00000);
        rst24_n = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
